serial_frame_rx: RTL

SERIAL_FRAME_RX -- requirements
Module: serial_frame_rx

---
 rtl/serial_frame_pkg.sv | 13 +
 rtl/frame_shift_reg.sv | 38 +++
 rtl/serial_frame_rx.sv | 130 +++++++++++++
 3 files changed

// File: rtl/serial_frame_pkg.sv
// Shared types and default framing constants for the serial frame receiver.
package serial_frame_pkg;

    typedef enum logic {
        HUNT = 1'b0,
        DATA = 1'b1
    } state_t;

    localparam int              DEF_WIDTH    = 8;
    localparam int              DEF_SYNC_LEN = 4;
    localparam logic [3:0]      DEF_SYNC     = 4'b1011;

endpackage

// File: rtl/frame_shift_reg.sv
// Parameterised shift register with enable and synchronous clear.
// LSB_FIRST=0 shifts toward the MSB (new bit at bit 0); LSB_FIRST=1 shifts toward the LSB.
module frame_shift_reg #(
    parameter int N         = 8,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic         C,
    input  logic         R,
    input  logic         en,
    input  logic         clr,
    input  logic         d,
    output logic [N-1:0] q
);

    logic [N-1:0] r_q;
    logic [N-1:0] w_shift;

    generate
        if (LSB_FIRST) begin : g_right
            assign w_shift = {d, r_q[N-1:1]};
        end else begin : g_left
            assign w_shift = {r_q[N-2:0], d};
        end
    endgenerate

    always_ff @(posedge C or negedge R) begin
        if (!R) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (en) begin
            r_q <= w_shift;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: hunts for a sync pattern, then collects WIDTH data bits
// LSB-first into a one-deep output register with valid/ready handshake.
//
// state | meaning
// HUNT  | shifting bits into the history register, looking for SYNC
// DATA  | collecting data bits; busy=1
module serial_frame_rx
    import serial_frame_pkg::*;
#(
    parameter int                  WIDTH    = DEF_WIDTH,
    parameter int                  SYNC_LEN = DEF_SYNC_LEN,
    parameter logic [SYNC_LEN-1:0] SYNC     = SYNC_LEN'(DEF_SYNC)
) (
    input  logic             C,
    input  logic             R,
    input  logic             si,
    input  logic             si_vld,
    output logic [WIDTH-1:0] dout,
    output logic             dout_vld,
    input  logic             dout_rdy,
    output logic             busy,
    output logic             ovf,
    output logic [7:0]       fcnt
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t              r_state, w_state_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
    logic [SYNC_LEN-1:0] w_hist;
    logic [SYNC_LEN-1:0] w_hist_shift;
    logic [WIDTH-1:0]    w_data;
    logic [WIDTH-1:0]    w_frame;
    logic [WIDTH-1:0]    r_dout;
    logic                r_dout_vld;
    logic                r_ovf;
    logic [7:0]          r_fcnt;
    logic                w_hunt_en, w_data_en;
    logic                w_match, w_last, w_load;

    assign w_hunt_en    = si_vld && (r_state == HUNT);
    assign w_data_en    = si_vld && (r_state == DATA);
    assign w_hist_shift = {w_hist[SYNC_LEN-2:0], si};
    assign w_match      = w_hunt_en && (w_hist_shift == SYNC);
    assign w_last       = w_data_en && (r_cnt == CNT_W'(WIDTH - 1));
    assign w_frame      = {si, w_data[WIDTH-1:1]};
    // The output register takes a new frame if it is empty or being drained this cycle.
    assign w_load       = w_last && (!r_dout_vld || dout_rdy);

    // History is cleared at frame end so the sync search never overlaps the data tail.
    frame_shift_reg #(.N(SYNC_LEN), .LSB_FIRST(1'b0)) u_hist (
        .C   (C),
        .R   (R),
        .en  (w_hunt_en),
        .clr (w_last),
        .d   (si),
        .q   (w_hist)
    );

    frame_shift_reg #(.N(WIDTH), .LSB_FIRST(1'b1)) u_data (
        .C   (C),
        .R   (R),
        .en  (w_data_en),
        .clr (w_match),
        .d   (si),
        .q   (w_data)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            HUNT: begin
                if (w_match) begin
                    w_state_nxt = DATA;
                    w_cnt_nxt   = '0;
                end
            end
            DATA: begin
                if (w_last) begin
                    w_state_nxt = HUNT;
                    w_cnt_nxt   = '0;
                end else if (w_data_en) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = HUNT;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge C or negedge R) begin
        if (!R) begin
            r_state <= HUNT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge C or negedge R) begin
        if (!R) begin
            r_dout     <= '0;
            r_dout_vld <= 1'b0;
            r_ovf      <= 1'b0;
            r_fcnt     <= '0;
        end else begin
            if (w_load) begin
                r_dout     <= w_frame;
                r_dout_vld <= 1'b1;
                r_fcnt     <= r_fcnt + 8'd1;
            end else if (r_dout_vld && dout_rdy) begin
                r_dout_vld <= 1'b0;
            end
            if (w_last && !w_load) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign dout     = r_dout;
    assign dout_vld = r_dout_vld;
    assign ovf      = r_ovf;
    assign fcnt     = r_fcnt;
    assign busy     = (r_state == DATA);

endmodule
